mfp_ahb_gpio_irq: RTL

MFP_AHB_GPIO_IRQ -- requirements
Module: mfp_ahb_gpio_irq

---
 rtl/mfp_ahb_gpio_irq.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mfp_ahb_gpio_irq.sv
// ---------------------------------------------------------------------------
// mfp_ahb_gpio_irq
//   AHB-Lite GPIO slave with per-pin edge-detect interrupts.
//
//   Register map (byte offsets, HADDR[1:0] ignored):
//     0x00 OUT      RW    output pin register
//     0x04 IN       RO    synchronized input pins
//     0x08 RISE_EN  RW    rising-edge interrupt enables
//     0x0C FALL_EN  RW    falling-edge interrupt enables
//     0x10 STATUS   RW1C  latched edge events
//     0x14 OUT_SET  WO    OUT |= data        (reads 0)
//     0x18 OUT_CLR  WO    OUT &= ~data       (reads 0)
//     0x1C reserved                          (reads 0)
//
//   Ports:
//     HCLK, HRESETn          clock, synchronous active-low reset
//     HADDR/HTRANS/HWRITE/HSEL  address-phase bus signals (registered)
//     HWDATA                 data-phase write data
//     HRDATA                 registered read data, decoded from live HADDR
//     IO_In  [N_IN-1:0]      asynchronous input pins
//     IO_Out [N_OUT-1:0]     registered output pins
//     IRQ                    registered level interrupt, |STATUS
// ---------------------------------------------------------------------------
module mfp_ahb_gpio_irq #(
    parameter int N_IN  = 16,
    parameter int N_OUT = 16
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic [4:0]        HADDR,
    input  logic [1:0]        HTRANS,
    input  logic [31:0]       HWDATA,
    input  logic              HWRITE,
    input  logic              HSEL,
    output logic [31:0]       HRDATA,
    input  logic [N_IN-1:0]   IO_In,
    output logic [N_OUT-1:0]  IO_Out,
    output logic              IRQ
);

    localparam logic [2:0] A_OUT     = 3'd0;
    localparam logic [2:0] A_IN      = 3'd1;
    localparam logic [2:0] A_RISE_EN = 3'd2;
    localparam logic [2:0] A_FALL_EN = 3'd3;
    localparam logic [2:0] A_STATUS  = 3'd4;
    localparam logic [2:0] A_OUT_SET = 3'd5;
    localparam logic [2:0] A_OUT_CLR = 3'd6;

    // Address-phase capture
    logic [2:0]        r_haddr;
    logic [1:0]        r_htrans;
    logic              r_hwrite;
    logic              r_hsel;

    // Register file
    logic [N_OUT-1:0]  r_out;
    logic [N_IN-1:0]   r_rise_en;
    logic [N_IN-1:0]   r_fall_en;
    logic [N_IN-1:0]   r_status;
    logic [31:0]       r_hrdata;
    logic              r_irq;

    // Input synchronizer and edge-detect history
    logic [N_IN-1:0]   r_sync_p0;
    logic [N_IN-1:0]   r_sync_p1;
    logic [N_IN-1:0]   r_prev;

    logic              w_we;
    logic [N_OUT-1:0]  w_wdata_out;
    logic [N_IN-1:0]   w_wdata_in;
    logic [N_IN-1:0]   w_rise;
    logic [N_IN-1:0]   w_fall;
    logic [N_IN-1:0]   w_event;
    logic [N_OUT-1:0]  w_out_nxt;
    logic [N_IN-1:0]   w_rise_en_nxt;
    logic [N_IN-1:0]   w_fall_en_nxt;
    logic [N_IN-1:0]   w_status_nxt;
    logic [31:0]       w_rdata;
    logic              w_unused;

    // Byte-lane bits of the address and high data bits beyond the pin
    // count carry no information for this block.
    assign w_unused = ^{HADDR[1:0], HWDATA};

    assign w_we        = r_hsel & r_hwrite & (r_htrans != 2'b00);
    assign w_wdata_out = HWDATA[N_OUT-1:0];
    assign w_wdata_in  = HWDATA[N_IN-1:0];

    assign w_rise  = r_sync_p1 & ~r_prev;
    assign w_fall  = ~r_sync_p1 & r_prev;
    assign w_event = (w_rise & r_rise_en) | (w_fall & r_fall_en);

    always_comb begin
        w_out_nxt     = r_out;
        w_rise_en_nxt = r_rise_en;
        w_fall_en_nxt = r_fall_en;
        w_status_nxt  = r_status;
        if (w_we) begin
            case (r_haddr)
                A_OUT:     w_out_nxt     = w_wdata_out;
                A_OUT_SET: w_out_nxt     = r_out | w_wdata_out;
                A_OUT_CLR: w_out_nxt     = r_out & ~w_wdata_out;
                A_RISE_EN: w_rise_en_nxt = w_wdata_in;
                A_FALL_EN: w_fall_en_nxt = w_wdata_in;
                A_STATUS:  w_status_nxt  = r_status & ~w_wdata_in;
                default:   ;
            endcase
        end
        // A new edge event overrides a same-cycle W1C on that bit.
        w_status_nxt = w_status_nxt | w_event;
    end

    always_comb begin
        w_rdata = '0;
        case (HADDR[4:2])
            A_OUT:     w_rdata[N_OUT-1:0] = r_out;
            A_IN:      w_rdata[N_IN-1:0]  = r_sync_p1;
            A_RISE_EN: w_rdata[N_IN-1:0]  = r_rise_en;
            A_FALL_EN: w_rdata[N_IN-1:0]  = r_fall_en;
            A_STATUS:  w_rdata[N_IN-1:0]  = r_status;
            default:   ;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_haddr   <= '0;
            r_htrans  <= '0;
            r_hwrite  <= 1'b0;
            r_hsel    <= 1'b0;
            r_out     <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_status  <= '0;
            r_hrdata  <= '0;
            r_irq     <= 1'b0;
            r_sync_p0 <= '0;
            r_sync_p1 <= '0;
            r_prev    <= '0;
        end else begin
            r_haddr   <= HADDR[4:2];
            r_htrans  <= HTRANS;
            r_hwrite  <= HWRITE;
            r_hsel    <= HSEL;
            r_out     <= w_out_nxt;
            r_rise_en <= w_rise_en_nxt;
            r_fall_en <= w_fall_en_nxt;
            r_status  <= w_status_nxt;
            r_hrdata  <= w_rdata;
            r_irq     <= |r_status;
            r_sync_p0 <= IO_In;
            r_sync_p1 <= r_sync_p0;
            r_prev    <= r_sync_p1;
        end
    end

    assign HRDATA = r_hrdata;
    assign IO_Out = r_out;
    assign IRQ    = r_irq;

endmodule
